multicycle_controller: RTL and testbench

Moore state machine that sequences the team's 16-bit multicycle datapath through fetch, decode, execute, memory and write-back. It consumes the decoded instruction fields and the latched PSR flags, and drives every mux select, register enable and write strobe the datapath exposes, plus the memory write enable. One instance sits beside the datapath in the CPU top level.

---
 rtl/isa_pkg.sv | 43 ++++
 rtl/cond_check.sv | 32 +++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 tb/tb_multicycle_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit multicycle CPU: opcodes, extensions,
// branch condition codes, PSR flag positions and the controller state encoding.
package isa_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_MOV   = 4'b1101;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // Extension field values used under OP_MEM
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_GT = 4'b0110;
  localparam logic [3:0] CC_LE = 4'b0111;
  localparam logic [3:0] CC_GE = 4'b1101;
  localparam logic [3:0] CC_UC = 4'b1110;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic [4:0] {
    S_FETCH, S_LATCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_CMP_R, S_CMP_I, S_WB,
    S_MOV, S_MOVI, S_LD_ADDR, S_LD_DATA, S_LD_WB, S_STOR, S_JCOND, S_JAL1,
    S_JAL2, S_BCOND
  } state_e;

endpackage

// File: rtl/cond_check.sv
// Branch/jump condition evaluation: condition code plus latched PSR flags -> taken.
module cond_check
  import isa_pkg::*;
#(
  parameter int PSRL = 5
) (
  input  logic [3:0]      cond,
  input  logic [PSRL-1:0] psr,
  output logic            taken
);

  // L and F flags never steer a branch
  logic unused_flags_s;
  assign unused_flags_s = psr[PSR_L] ^ psr[PSR_F];

  // Decode the condition code against the flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = psr[PSR_Z];
      CC_NE:   taken = ~psr[PSR_Z];
      CC_CS:   taken = psr[PSR_C];
      CC_CC:   taken = ~psr[PSR_C];
      CC_GT:   taken = psr[PSR_N];
      CC_LE:   taken = ~psr[PSR_N];
      CC_GE:   taken = psr[PSR_N] | psr[PSR_Z];
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller sequencing the 16-bit multicycle datapath through
// fetch, decode, execute, memory and write-back.
module multicycle_controller
  import isa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PSRL  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      OP_CODE,
  input  logic [3:0]      OP_EXT,
  input  logic [3:0]      Rdest_addr,
  input  logic [PSRL-1:0] PSR_OUT,
  output logic            PC_S,
  output logic            MEM_DATA_S,
  output logic [1:0]      MEM_S,
  output logic [1:0]      WD_S,
  output logic [1:0]      ALUA_S,
  output logic [1:0]      ALUB_S,
  output logic            INSTR_EN,
  output logic            ALU_OUT_EN,
  output logic            MEM_REG_EN,
  output logic            PC_EN,
  output logic            PSR_EN,
  output logic            SE_SIGN,
  output logic            REG_WR,
  output logic            MEM_WE
);

  state_e state_r;
  state_e next_state_s;
  logic   taken_s;

  // WIDTH only documents which datapath this controller pairs with
  logic [WIDTH-1:0] unused_width_s;
  assign unused_width_s = '0;

  cond_check #(.PSRL(PSRL)) u_cond_check (
    .cond  (Rdest_addr),
    .psr   (PSR_OUT),
    .taken (taken_s)
  );

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= next_state_s;
  end

  // Next-state dispatch and Moore outputs (condition result only in JCOND/BCOND)
  always_comb begin
    next_state_s = S_FETCH;
    PC_S = 1'b0;       MEM_DATA_S = 1'b0;  MEM_S = 2'b01;     WD_S = 2'b00;
    ALUA_S = 2'b00;    ALUB_S = 2'b00;     INSTR_EN = 1'b0;   ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0; PC_EN = 1'b0;       PSR_EN = 1'b0;     SE_SIGN = 1'b0;
    REG_WR = 1'b0;     MEM_WE = 1'b0;
    case (state_r)
      S_FETCH: next_state_s = S_LATCH;
      S_LATCH: begin
        INSTR_EN = 1'b1; PC_EN = 1'b1; PC_S = 1'b1; ALUA_S = 2'b01; ALUB_S = 2'b10;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        case (OP_CODE)
          OP_RTYPE: begin
            case (OP_EXT)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: next_state_s = S_EXEC_R;
              OP_CMP:  next_state_s = S_CMP_R;
              OP_MOV:  next_state_s = S_MOV;
              default: next_state_s = S_FETCH;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: next_state_s = S_EXEC_I;
          OP_CMP: next_state_s = S_CMP_I;
          OP_MOV: next_state_s = S_MOVI;
          OP_MEM: begin
            case (OP_EXT)
              EXT_LOAD:  next_state_s = S_LD_ADDR;
              EXT_STOR:  next_state_s = S_STOR;
              EXT_JCOND: next_state_s = S_JCOND;
              EXT_JAL:   next_state_s = S_JAL1;
              default:   next_state_s = S_FETCH;
            endcase
          end
          OP_BCOND: next_state_s = S_BCOND;
          default:  next_state_s = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        ALU_OUT_EN = 1'b1; PSR_EN = 1'b1;
        next_state_s = S_WB;
      end
      S_EXEC_I: begin
        ALUA_S = 2'b10; ALU_OUT_EN = 1'b1; PSR_EN = 1'b1;
        SE_SIGN = (OP_CODE == OP_ADD) || (OP_CODE == OP_SUB);
        next_state_s = S_WB;
      end
      S_CMP_R: PSR_EN = 1'b1;
      S_CMP_I: begin
        ALUA_S = 2'b10; PSR_EN = 1'b1; SE_SIGN = 1'b1;
      end
      S_WB: begin
        REG_WR = 1'b1; WD_S = 2'b11;
      end
      S_MOV: begin
        REG_WR = 1'b1; WD_S = 2'b01;
      end
      S_MOVI: REG_WR = 1'b1;
      S_LD_ADDR: begin
        MEM_S = 2'b00;
        next_state_s = S_LD_DATA;
      end
      S_LD_DATA: begin
        MEM_S = 2'b00; MEM_REG_EN = 1'b1;
        next_state_s = S_LD_WB;
      end
      S_LD_WB: begin
        REG_WR = 1'b1; WD_S = 2'b10;
      end
      S_STOR: begin
        MEM_S = 2'b00; MEM_WE = 1'b1;
      end
      S_JCOND: PC_EN = taken_s;
      S_JAL1: begin
        PC_EN = 1'b1; ALUA_S = 2'b01; ALUB_S = 2'b11; ALU_OUT_EN = 1'b1;
        next_state_s = S_JAL2;
      end
      S_JAL2: begin
        REG_WR = 1'b1; WD_S = 2'b11;
      end
      // PC <= PC+1+disp; the PC already holds PC+1 from LATCH
      S_BCOND: begin
        SE_SIGN = 1'b1; ALUA_S = 2'b01; ALUB_S = 2'b01;
        PC_EN = taken_s; PC_S = taken_s;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state
// by state and compares the packed control word against hand-derived values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] OP_CODE, OP_EXT, Rdest_addr;
  logic [4:0] PSR_OUT;
  logic       PC_S, MEM_DATA_S, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN;
  logic       SE_SIGN, REG_WR, MEM_WE;
  logic [1:0] MEM_S, WD_S, ALUA_S, ALUB_S;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller #(.WIDTH(16), .PSRL(5)) dut (
    .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .OP_EXT(OP_EXT),
    .Rdest_addr(Rdest_addr), .PSR_OUT(PSR_OUT), .PC_S(PC_S),
    .MEM_DATA_S(MEM_DATA_S), .MEM_S(MEM_S), .WD_S(WD_S), .ALUA_S(ALUA_S),
    .ALUB_S(ALUB_S), .INSTR_EN(INSTR_EN), .ALU_OUT_EN(ALU_OUT_EN),
    .MEM_REG_EN(MEM_REG_EN), .PC_EN(PC_EN), .PSR_EN(PSR_EN),
    .SE_SIGN(SE_SIGN), .REG_WR(REG_WR), .MEM_WE(MEM_WE)
  );

  always #5 clk = ~clk;

  // Packed control word: PC_S MDS MEM_S WD_S ALUA ALUB IE AOE MRE PCE PSRE SE RW WE
  logic [17:0] obs;
  assign obs = {PC_S, MEM_DATA_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN,
                MEM_REG_EN, PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE};

  function automatic logic [17:0] cw(input logic pc_s, input logic mds,
      input logic [1:0] mem_s, input logic [1:0] wd_s, input logic [1:0] alua,
      input logic [1:0] alub, input logic ie, input logic aoe, input logic mre,
      input logic pce, input logic psre, input logic se, input logic rw,
      input logic we);
    return {pc_s, mds, mem_s, wd_s, alua, alub, ie, aoe, mre, pce, psre, se, rw, we};
  endfunction

  logic [17:0] e_fetch, e_latch, e_exec_r, e_exec_i_s, e_exec_i_z, e_wb, e_cmp_r,
               e_cmp_i, e_mov, e_movi, e_ld_addr, e_ld_data, e_ld_wb, e_stor,
               e_j_tk, e_b_tk, e_b_nt, e_jal1, e_jal2;

  task automatic chk(input string tag, input logic [17:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [17:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] ext,
                       input logic [3:0] rd, input logic [4:0] psr);
    OP_CODE = op; OP_EXT = ext; Rdest_addr = rd; PSR_OUT = psr;
  endtask

  // One Jcond instruction from FETCH back to FETCH
  task automatic jcond(input string tag, input logic [3:0] cc, input logic [4:0] psr,
                       input logic [17:0] exp);
    instr(4'b0100, 4'b1100, cc, psr);
    step({tag, "_latch"}, e_latch);
    step({tag, "_decode"}, e_fetch);
    step({tag, "_jcond"}, exp);
    step({tag, "_fetch"}, e_fetch);
  endtask

  initial begin
    e_fetch    = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_latch    = cw(1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_exec_r   = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_exec_i_s = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_exec_i_z = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_wb       = cw(1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_cmp_r    = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_cmp_i    = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_mov      = cw(1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_movi     = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_ld_addr  = cw(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_ld_data  = cw(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_ld_wb    = cw(1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    e_stor     = cw(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e_j_tk     = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_b_tk     = cw(1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    e_b_nt     = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e_jal1     = cw(1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_jal2     = e_wb;

    reset = 1'b1;
    instr(4'b0000, 4'b0000, 4'b0000, 5'b00000);
    step("reset_1", e_fetch);
    step("reset_2", e_fetch);
    reset = 1'b0;

    // ADD (R-type): 5 cycles
    instr(4'b0000, 4'b0101, 4'b0000, 5'b00000);
    step("add_latch", e_latch); step("add_decode", e_fetch);
    step("add_exec", e_exec_r); step("add_wb", e_wb); step("add_fetch", e_fetch);

    // SUBI sign-extends, ORI zero-extends
    instr(4'b1001, 4'b0000, 4'b0000, 5'b00000);
    step("subi_latch", e_latch); step("subi_decode", e_fetch);
    step("subi_exec", e_exec_i_s); step("subi_wb", e_wb); step("subi_fetch", e_fetch);
    instr(4'b0010, 4'b0000, 4'b0000, 5'b00000);
    step("ori_latch", e_latch); step("ori_decode", e_fetch);
    step("ori_exec", e_exec_i_z); step("ori_wb", e_wb); step("ori_fetch", e_fetch);

    // CMP, CMPI, MOV, MOVI: 4 cycles each
    instr(4'b0000, 4'b1011, 4'b0000, 5'b00000);
    step("cmp_latch", e_latch); step("cmp_decode", e_fetch);
    step("cmp_exec", e_cmp_r); step("cmp_fetch", e_fetch);
    instr(4'b1011, 4'b0000, 4'b0000, 5'b00000);
    step("cmpi_latch", e_latch); step("cmpi_decode", e_fetch);
    step("cmpi_exec", e_cmp_i); step("cmpi_fetch", e_fetch);
    instr(4'b0000, 4'b1101, 4'b0000, 5'b00000);
    step("mov_latch", e_latch); step("mov_decode", e_fetch);
    step("mov_wr", e_mov); step("mov_fetch", e_fetch);
    instr(4'b1101, 4'b0000, 4'b0000, 5'b00000);
    step("movi_latch", e_latch); step("movi_decode", e_fetch);
    step("movi_wr", e_movi); step("movi_fetch", e_fetch);

    // LOAD: 6 cycles
    instr(4'b0100, 4'b0000, 4'b0000, 5'b00000);
    step("ld_latch", e_latch); step("ld_decode", e_fetch);
    step("ld_addr", e_ld_addr); step("ld_data", e_ld_data);
    step("ld_wb", e_ld_wb); step("ld_fetch", e_fetch);

    // STOR
    instr(4'b0100, 4'b0100, 4'b0000, 5'b00000);
    step("st_latch", e_latch); step("st_decode", e_fetch);
    step("st_we", e_stor); step("st_fetch", e_fetch);

    // BCOND EQ taken with Z=1, not taken with Z=0
    instr(4'b1100, 4'b0000, 4'b0000, 5'b01000);
    step("beq_latch", e_latch); step("beq_decode", e_fetch);
    step("beq_taken", e_b_tk); step("beq_fetch", e_fetch);
    instr(4'b1100, 4'b0000, 4'b0000, 5'b00000);
    step("bne_latch", e_latch); step("bne_decode", e_fetch);
    step("beq_not_taken", e_b_nt); step("bne_fetch", e_fetch);

    // JCOND across condition codes
    jcond("j_ne",    4'b0001, 5'b00000, e_j_tk);
    jcond("j_eq_nt", 4'b0000, 5'b10111, e_fetch);
    jcond("j_cs",    4'b0010, 5'b00001, e_j_tk);
    jcond("j_cc_nt", 4'b0011, 5'b00001, e_fetch);
    jcond("j_gt",    4'b0110, 5'b10000, e_j_tk);
    jcond("j_le_nt", 4'b0111, 5'b10000, e_fetch);
    jcond("j_ge_z",  4'b1101, 5'b01000, e_j_tk);
    jcond("j_ge_nt", 4'b1101, 5'b00111, e_fetch);
    jcond("j_uc",    4'b1110, 5'b00000, e_j_tk);
    jcond("j_never", 4'b0100, 5'b11111, e_fetch);

    // JAL: 5 cycles
    instr(4'b0100, 4'b1000, 4'b0000, 5'b00000);
    step("jal_latch", e_latch); step("jal_decode", e_fetch);
    step("jal1", e_jal1); step("jal2", e_jal2); step("jal_fetch", e_fetch);

    // NOP: 3 cycles, next LATCH follows immediately
    instr(4'b1111, 4'b0000, 4'b0000, 5'b00000);
    step("nop_latch", e_latch); step("nop_decode", e_fetch);
    step("nop_fetch", e_fetch); step("nop_next_latch", e_latch);
    step("nop_next_decode", e_fetch); step("nop_next_fetch", e_fetch);

    // Reset held 3 cycles mid-LOAD abandons the load
    instr(4'b0100, 4'b0000, 4'b0000, 5'b00000);
    step("rl_latch", e_latch); step("rl_decode", e_fetch); step("rl_addr", e_ld_addr);
    reset = 1'b1;
    step("rl_reset_1", e_fetch); step("rl_reset_2", e_fetch); step("rl_reset_3", e_fetch);
    reset = 1'b0;
    chk("rl_after_reset", e_fetch);
    step("rl_restart_latch", e_latch); step("rl_restart_decode", e_fetch);
    step("rl_restart_addr", e_ld_addr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
